pc_fetch_unit: RTL and testbench

Instruction-fetch front end of the Titan core: owns the program counter, issues word fetches to instruction memory over a single-outstanding req/ack handshake, and presents `{pc, instruction}` pairs to decode. It is the producer of the `pc` value that decode and the PC benches sample. It handles reset to a fixed boot address, sequential +4 advance, branch/jump redirects and decode back-pressure without losing or duplicating instructions.

---
 rtl/pc_fetch_unit_pkg.sv | 29 ++
 rtl/fetch_skid_reg.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-path definitions: datapath width, boot address, NOP encoding
// and the fetch FSM state type used by the fetch unit and its skid buffer.
package pc_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;
    localparam logic [XLEN-1:0] FETCH_STRIDE       = 32'h0000_0004;
    localparam logic [XLEN-1:0] ALIGN_MASK         = 32'h0000_0003;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid buffer holding a fetched {pc, instr, fault} that arrived
// while decode was stalling the output register.
module fetch_skid_reg
    import pc_fetch_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            fault_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            fault_o
);

    fetch_entry_t entry_q;
    fetch_entry_t entry_d;
    logic         valid_q;
    logic         valid_d;

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            entry_d.pc    = pc_i;
            entry_d.instr = instr_i;
            entry_d.fault = fault_i;
            valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = entry_q.pc;
    assign instr_o = entry_q.instr;
    assign fault_o = entry_q.fault;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding word
// fetches and presents {pc, instr} to decode with stall and redirect handling.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        imem_err_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        fault_o
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic            req_en_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_d;
    logic            valid_q;
    logic            valid_d;
    logic            fault_q;
    logic            fault_d;

    logic            req;
    logic            ack_ok;
    logic            out_free;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] addr_inc;

    logic            skid_load;
    logic            skid_clear;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;
    logic            skid_fault;

    // The request is masked for one cycle after reset so the boot fetch
    // starts cleanly one cycle after rst_i falls.
    assign req       = req_en_q && (state_q != ST_HOLD);
    assign ack_ok    = imem_ack_i && req;
    assign out_free  = !valid_q || !stall_i;
    assign redir_tgt = word_align(redirect_pc_i);
    assign addr_inc  = addr_q + FETCH_STRIDE;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_FETCH;
            req_en_q <= 1'b0;
            addr_q   <= RESET_ADDR;
            target_q <= RESET_ADDR;
            pc_q     <= RESET_ADDR;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_en_q <= 1'b1;
            addr_q   <= addr_d;
            target_q <= target_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and fetch-address logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        if (redirect_i) begin
            target_d = redir_tgt;
        end
        case (state_q)
            ST_FETCH: begin
                if (redirect_i) begin
                    // An unanswered request must complete at its old address
                    // before the target can be issued.
                    if (ack_ok || !req) begin
                        addr_d = redir_tgt;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if (ack_ok) begin
                    addr_d = addr_inc;
                    if (!out_free) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    addr_d  = redir_tgt;
                    state_d = ST_FETCH;
                end else if (!stall_i || !skid_valid) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (ack_ok) begin
                    state_d = ST_FETCH;
                    addr_d  = redirect_i ? redir_tgt : target_q;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output register and skid control
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect_i) begin
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            fault_d    = 1'b0;
            skid_clear = 1'b1;
        end else if ((state_q == ST_FETCH) && ack_ok && out_free) begin
            pc_d    = addr_q;
            instr_d = imem_data_i;
            fault_d = imem_err_i;
            valid_d = 1'b1;
        end else if ((state_q == ST_FETCH) && ack_ok) begin
            skid_load = 1'b1;
        end else if ((state_q == ST_HOLD) && !stall_i && skid_valid) begin
            pc_d       = skid_pc;
            instr_d    = skid_instr;
            fault_d    = skid_fault;
            valid_d    = 1'b1;
            skid_clear = 1'b1;
        end else if (!stall_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            fault_d = 1'b0;
        end
    end

    fetch_skid_reg u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (addr_q),
        .instr_i (imem_data_i),
        .fault_i (imem_err_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .fault_o (skid_fault)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = addr_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a small latency-programmable memory model
// answers fetches with data = addr ^ 32'hA5A5_0000.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        imem_err;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;

    int          lat;
    int          lat_cnt;
    logic [31:0] err_addr;
    int          checks;
    int          errors;

    pc_fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .imem_err_i    (imem_err),
        .pc_o          (pc),
        .instr_o       (instr),
        .valid_o       (valid),
        .fault_o       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack  = imem_req && (lat_cnt == lat);
    assign imem_data = imem_ack ? (imem_addr ^ KEY) : 32'h0;
    assign imem_err  = imem_ack && (imem_addr == err_addr);

    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        lat         = 0;
        lat_cnt     = 0;
        err_addr    = 32'hFFFF_FFF0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset and sequential fetch
        repeat (5) tick();
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        rst = 1'b0;
        check("post_rst_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("seq_pc0", pc, 32'h0);
        check("seq_v0", {31'b0, valid}, 32'h1);
        check("seq_i0", instr, 32'hA5A5_0000);
        tick();
        check("seq_pc4", pc, 32'h4);
        tick();
        check("seq_pc8", pc, 32'h8);
        tick();
        check("seq_pcC", pc, 32'hC);
        check("seq_vC", {31'b0, valid}, 32'h1);

        // Stall with skid: ack for 0x8 while pc=0x4 is held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("stl_pc4", pc, 32'h4);
        check("stl_addr8", imem_addr, 32'h8);
        stall = 1'b1;
        tick();
        check("stl_hold_pc", pc, 32'h4);
        check("stl_req_off", {31'b0, imem_req}, 32'h0);
        check("stl_valid", {31'b0, valid}, 32'h1);
        tick();
        check("stl_hold_pc2", pc, 32'h4);
        stall = 1'b0;
        tick();
        check("stl_pc8", pc, 32'h8);
        check("stl_i8", instr, 32'hA5A5_0008);
        tick();
        check("stl_pcC", pc, 32'hC);

        // Redirect during an outstanding request with 3-cycle latency
        lat = 3;
        check("flu_issue", imem_addr, 32'h10);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("flu_addr_a", imem_addr, 32'h10);
        check("flu_req", {31'b0, imem_req}, 32'h1);
        check("flu_valid_a", {31'b0, valid}, 32'h0);
        tick();
        check("flu_addr_b", imem_addr, 32'h10);
        check("flu_valid_b", {31'b0, valid}, 32'h0);
        tick();
        check("flu_valid_c", {31'b0, valid}, 32'h0);
        check("flu_tgt_addr", imem_addr, 32'h100);
        lat = 0;
        tick();
        check("flu_pc", pc, 32'h100);
        check("flu_instr", instr, 32'hA5A5_0100);
        check("flu_valid_d", {31'b0, valid}, 32'h1);

        // Misaligned redirect and wrap-around
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        check("mis_addr", imem_addr, 32'h100);
        check("mis_valid", {31'b0, valid}, 32'h0);
        tick();
        check("mis_pc", pc, 32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_next", imem_addr, 32'h0);
        tick();
        check("wrap_pc0", pc, 32'h0);
        check("wrap_i0", instr, 32'hA5A5_0000);

        // Fault on 0x20, fetching continues
        err_addr    = 32'h20;
        redirect    = 1'b1;
        redirect_pc = 32'h1C;
        tick();
        redirect = 1'b0;
        tick();
        check("flt_pc1C", pc, 32'h1C);
        check("flt_f1C", {31'b0, fault}, 32'h0);
        tick();
        check("flt_pc20", pc, 32'h20);
        check("flt_f20", {31'b0, fault}, 32'h1);
        tick();
        check("flt_pc24", pc, 32'h24);
        check("flt_f24", {31'b0, fault}, 32'h0);
        check("flt_v24", {31'b0, valid}, 32'h1);

        // Reset while in FLUSH
        lat         = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("mrs_flush_a", imem_addr, 32'h28);
        check("mrs_flush_v", {31'b0, valid}, 32'h0);
        rst = 1'b1;
        tick();
        check("mrs_req", {31'b0, imem_req}, 32'h0);
        check("mrs_addr", imem_addr, 32'h0);
        check("mrs_pc", pc, 32'h0);
        check("mrs_instr", instr, NOP);
        check("mrs_valid", {31'b0, valid}, 32'h0);
        check("mrs_fault", {31'b0, fault}, 32'h0);
        rst = 1'b0;
        lat = 0;
        tick();
        check("mrs_req_up", {31'b0, imem_req}, 32'h1);
        check("mrs_addr_up", imem_addr, 32'h0);
        tick();
        check("mrs_pc0", pc, 32'h0);
        check("mrs_v0", {31'b0, valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
